// File: rtl/mandel_vga_readout.sv
// VGA readout for the Mandelbrot engine: fetches 4-bit iteration counts from sequential memory
// into a one-row line buffer, upscales by SCALE and drives registered sync/colour outputs.
module mandel_vga_readout #(
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33,
    parameter int unsigned IMG_W     = 80,
    parameter int unsigned IMG_H     = 60,
    parameter int unsigned SCALE     = 8,
    parameter int unsigned RD_LAT    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_valid,
    input  logic [3:0] mem_data,
    output logic       mem_read,
    output logic       mem_reset_ptr,
    output logic       hsync,
    output logic       vsync,
    output logic [1:0] red,
    output logic [1:0] green,
    output logic [1:0] blue,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);
    localparam int unsigned LW      = $clog2(IMG_W);

    localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS_END = HW'(H_VISIBLE);
    localparam logic [HW-1:0] HS_START  = HW'(H_VISIBLE + H_FRONT);
    localparam logic [HW-1:0] HS_END    = HW'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [HW-1:0] FETCH_END = HW'(H_VISIBLE + IMG_W);
    localparam logic [HW-1:0] H_SCALE   = HW'(SCALE);
    localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_VIS_END = VW'(V_VISIBLE);
    localparam logic [VW-1:0] VS_START  = VW'(V_VISIBLE + V_FRONT);
    localparam logic [VW-1:0] VS_END    = VW'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [HW-1:0]     h_q, h_d;
    logic [VW-1:0]     v_q, v_d;
    logic              show_q, show_d;
    logic [RD_LAT-1:0] rd_pipe_q, rd_pipe_d;
    logic [LW-1:0]     wr_idx_q, wr_idx_d;
    logic              hsync_q, hsync_d;
    logic              vsync_q, vsync_d;
    logic [1:0]        red_q, red_d;
    logic [1:0]        green_q, green_d;
    logic [1:0]        blue_q, blue_d;
    logic              setup_q, setup_d;
    logic [3:0]        linebuf_q [IMG_W];

    logic              visible_c;
    logic              fetch_line_c;
    logic              rd_c;
    logic              cap_c;
    logic [LW-1:0]     rd_idx_c;
    logic [3:0]        pix_c;

    // Next-state and next-output logic, all a function of the current counters.
    always_comb begin
        h_d          = h_q + HW'(1);
        v_d          = v_q;
        show_d       = show_q;
        wr_idx_d     = wr_idx_q;
        fetch_line_c = 1'b0;
        red_d        = 2'd0;
        green_d      = 2'd0;
        blue_d       = 2'd0;

        if (h_q == H_LAST) begin
            h_d = '0;
            v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
        end

        setup_d = (h_q == '0) && (v_q == VS_START);
        if (setup_d) begin
            show_d = frame_valid;
        end

        hsync_d = !((h_q >= HS_START) && (h_q < HS_END));
        vsync_d = !((v_q >= VS_START) && (v_q < VS_END));

        // Row 0 is fetched on the last line of the frame, row r on the line before its first display line.
        if (v_q == V_LAST) begin
            fetch_line_c = 1'b1;
        end
        for (int unsigned r = 1; r < IMG_H; r++) begin
            if (v_q == VW'(r * SCALE - 1)) begin
                fetch_line_c = 1'b1;
            end
        end
        rd_c      = show_q && fetch_line_c && (h_q >= H_VIS_END) && (h_q < FETCH_END);
        rd_pipe_d = RD_LAT'({rd_pipe_q, rd_c});
        cap_c     = rd_pipe_q[RD_LAT-1];

        if (h_q == '0) begin
            wr_idx_d = '0;
        end else if (cap_c) begin
            wr_idx_d = wr_idx_q + LW'(1);
        end

        visible_c = (h_q < H_VIS_END) && (v_q < V_VIS_END);
        rd_idx_c  = visible_c ? LW'(h_q / H_SCALE) : '0;
        pix_c     = linebuf_q[rd_idx_c];

        // Count 15 means inside the set and is painted black.
        if (visible_c && show_q && (pix_c != 4'hF)) begin
            red_d   = pix_c[3:2];
            green_d = pix_c[1:0];
            blue_d  = ~pix_c[3:2];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_q       <= '0;
            v_q       <= '0;
            show_q    <= 1'b0;
            rd_pipe_q <= '0;
            wr_idx_q  <= '0;
            hsync_q   <= 1'b1;
            vsync_q   <= 1'b1;
            red_q     <= 2'd0;
            green_q   <= 2'd0;
            blue_q    <= 2'd0;
            setup_q   <= 1'b0;
        end else begin
            h_q       <= h_d;
            v_q       <= v_d;
            show_q    <= show_d;
            rd_pipe_q <= rd_pipe_d;
            wr_idx_q  <= wr_idx_d;
            hsync_q   <= hsync_d;
            vsync_q   <= vsync_d;
            red_q     <= red_d;
            green_q   <= green_d;
            blue_q    <= blue_d;
            setup_q   <= setup_d;
        end
    end

    // Line buffer storage carries no reset; stale contents are never shown while show is low.
    always_ff @(posedge clk) begin
        if (cap_c) begin
            linebuf_q[wr_idx_q] <= mem_data;
        end
    end

    assign mem_read      = rd_pipe_q[0];
    assign mem_reset_ptr = setup_q;
    assign frame_start   = setup_q;
    assign hsync         = hsync_q;
    assign vsync         = vsync_q;
    assign red           = red_q;
    assign green         = green_q;
    assign blue          = blue_q;

endmodule

// File: tb/tb_mandel_vga_readout.sv
// Scoreboard bench for mandel_vga_readout on a reduced raster so several whole frames fit in
// a short run; an external memory model serves the sequential reads.
module tb_mandel_vga_readout;

    localparam int HV = 64;
    localparam int HF = 4;
    localparam int HS = 8;
    localparam int HB = 12;
    localparam int VV = 16;
    localparam int VF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int IW = 16;
    localparam int IH = 4;
    localparam int SC = 4;
    localparam int RL = 2;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
        logic       rd;
        logic       rp;
        logic       fs;
    } out_t;

    typedef struct packed {
        out_t        o;
        logic        rst;
        logic        show;
        logic        nshow;
        logic [1:0]  mode;
        logic [15:0] h;
        logic [15:0] v;
    } exp_t;

    typedef struct packed {
        int         m;
        int         h;
        int         v;
        logic [5:0] rgb;
    } chk_t;

    logic       clk;
    logic       rst_n;
    logic       frame_valid;
    logic [3:0] mem_data;
    logic       mem_read;
    logic       mem_reset_ptr;
    logic       hsync;
    logic       vsync;
    logic [1:0] red;
    logic [1:0] green;
    logic [1:0] blue;
    logic       frame_start;

    int   n_vec;
    int   n_bad;
    int   cur_mode;
    int   mh;
    int   mv;
    logic mshow;
    int   mmode;
    int   mem_ptr;
    int   mem_mode;
    exp_t exp_q[$];

    // Hand-computed colours at chosen pixels, {red, green, blue}
    chk_t tab [12] = '{
        '{0,  0,  0, 6'b000011}, '{0,  4,  0, 6'b000111}, '{0,  0,  3, 6'b000011},
        '{0,  4,  3, 6'b000111}, '{0,  0,  4, 6'b000011}, '{0, 52,  4, 6'b110100},
        '{1, 20,  9, 6'b000000}, '{2,  0,  0, 6'b011010}, '{2, 63, 15, 6'b011010},
        '{3,  0,  4, 6'b001111}, '{3, 48,  0, 6'b110000}, '{3, 60, 12, 6'b101101}
    };

    mandel_vga_readout #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .IMG_W(IW), .IMG_H(IH), .SCALE(SC), .RD_LAT(RL)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_valid  (frame_valid),
        .mem_data     (mem_data),
        .mem_read     (mem_read),
        .mem_reset_ptr(mem_reset_ptr),
        .hsync        (hsync),
        .vsync        (vsync),
        .red          (red),
        .green        (green),
        .blue         (blue),
        .frame_start  (frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [3:0] memfn(input int mode, input int addr);
        case (mode)
            0:       return 4'(addr % 16);
            1:       return 4'hF;
            2:       return 4'b0110;
            default: return 4'(addr % 13);
        endcase
    endfunction

    function automatic out_t exp_out(input int h, input int v, input logic show, input int mode);
        out_t       o;
        logic       fetch;
        logic [3:0] idx;
        o      = '0;
        o.hs   = !(h >= HV + HF && h < HV + HF + HS);
        o.vs   = !(v >= VV + VF && v < VV + VF + VS);
        o.rp   = (h == 0) && (v == VV + VF);
        o.fs   = o.rp;
        fetch  = (v == VT - 1) || (((v + 1) % SC == 0) && (v + 1 < VV));
        o.rd   = show && fetch && (h >= HV) && (h < HV + IW);
        if (show && h < HV && v < VV) begin
            idx = memfn(mode, (v / SC) * IW + h / SC);
            if (idx != 4'hF) begin
                o.r = idx[3:2];
                o.g = idx[1:0];
                o.b = ~idx[3:2];
            end
        end
        return o;
    endfunction

    // Sequential-access memory: one register stage after the strobe, pointer post-increment.
    always @(posedge clk) begin
        if (mem_reset_ptr) begin
            mem_ptr  <= 0;
            mem_mode <= cur_mode;
        end else if (mem_read) begin
            mem_data <= memfn(mem_mode, mem_ptr);
            mem_ptr  <= mem_ptr + 1;
        end
    end

    // Reference raster: pushes the output the DUT must present after each clock edge.
    initial begin
        exp_t e;
        mh = 0; mv = 0; mshow = 1'b0; mmode = 0;
        forever begin
            @(posedge clk);
            e   = '0;
            e.h = 16'(mh);
            e.v = 16'(mv);
            if (!rst_n) begin
                e.rst  = 1'b1;
                e.o.hs = 1'b1;
                e.o.vs = 1'b1;
                mh = 0; mv = 0; mshow = 1'b0;
            end else begin
                e.o     = exp_out(mh, mv, mshow, mmode);
                e.show  = mshow;
                e.mode  = 2'(mmode);
                e.nshow = frame_valid;
                if (mh == 0 && mv == VV + VF) begin
                    mshow = frame_valid;
                    mmode = cur_mode;
                end
                if (mh == HT - 1) begin
                    mh = 0;
                    mv = (mv == VT - 1) ? 0 : mv + 1;
                end else begin
                    mh = mh + 1;
                end
            end
            exp_q.push_back(e);
        end
    end

    // Monitor: pops one expectation per clock and compares away from the active edge.
    initial begin
        exp_t e;
        out_t got;
        int   strobes;
        int   want;
        logic cnt_ok;
        logic prev_show;
        n_vec = 0; n_bad = 0; strobes = 0; cnt_ok = 1'b0; prev_show = 1'b0;
        forever begin
            @(negedge clk);
            if (exp_q.size() != 0) begin
                e   = exp_q.pop_front();
                got = {hsync, vsync, red, green, blue, mem_read, mem_reset_ptr, frame_start};
                n_vec++;
                if (got !== e.o) begin
                    n_bad++;
                    $display("FAIL outputs h=%0d v=%0d got=%b want=%b", e.h, e.v, got, e.o);
                end
                if (e.rst) begin
                    cnt_ok  = 1'b0;
                    strobes = 0;
                end else begin
                    if (e.o.fs) begin
                        if (cnt_ok) begin
                            want = prev_show ? IW * IH : 0;
                            n_vec++;
                            if (strobes != want) begin
                                n_bad++;
                                $display("FAIL strobes_per_frame got=%0d want=%0d", strobes, want);
                            end
                        end
                        cnt_ok    = 1'b1;
                        prev_show = e.nshow;
                        strobes   = 0;
                    end
                    if (mem_read === 1'b1) strobes++;
                    if (e.show) begin
                        for (int i = 0; i < 12; i++) begin
                            if (tab[i].m == int'(e.mode) && tab[i].h == int'(e.h) && tab[i].v == int'(e.v)) begin
                                n_vec++;
                                if ({red, green, blue} !== tab[i].rgb) begin
                                    n_bad++;
                                    $display("FAIL pixel m=%0d h=%0d v=%0d got=%b want=%b",
                                             tab[i].m, e.h, e.v, {red, green, blue}, tab[i].rgb);
                                end
                            end
                        end
                    end
                end
            end
        end
    end

    task automatic wait_hv(input int h, input int v);
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (mh == h && mv == v) return;
        end
        n_bad++;
        $display("FAIL wait_position h=%0d v=%0d got=timeout want=reached", h, v);
    endtask

    // Stimulus: black frames, enable mid-frame, palette modes, reset during a fetch line.
    initial begin
        rst_n       = 1'b1;
        frame_valid = 1'b0;
        cur_mode    = 0;
        #2 rst_n    = 1'b0;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;

        wait_hv(0, 5);
        wait_hv(0, 5);
        #1 frame_valid = 1'b1;
        wait_hv(0, 5);
        #1 cur_mode = 1;
        wait_hv(0, 5);
        #1 cur_mode = 2;
        wait_hv(0, 5);
        #1 cur_mode = 3;
        wait_hv(HV + 4, 7);
        #1 rst_n = 1'b0;
        repeat (100) @(negedge clk);
        #1 rst_n = 1'b1;

        wait_hv(2, VV + VF);
        wait_hv(2, VV + VF);
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
